// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
//   Types and constants shared by the AXI bridge read path: the read routing
//   state (also consumed by the read-data channel mux), master index
//   constants, the default S1 address select bit and the target decoder.
//   AXI widths come from the common include. The guarded fallbacks below let
//   this slice elaborate on its own and step aside when that include is
//   already loaded.
// ---------------------------------------------------------------------------
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

package axi_pkg;

    // Read routing select; the encoding is fixed because the data mux decodes it.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        R_M0_S0 = 3'd1,
        R_M1_S0 = 3'd2,
        R_M1_S1 = 3'd3
    } r_state_t;

    localparam logic M0_IDX = 1'b0;
    localparam logic M1_IDX = 1'b1;

    localparam int S1_BASE_BIT_DEFAULT = 16;

    // Route for a granted master: M0 only ever reaches S0; M1 is steered by
    // its address select bit.
    function automatic r_state_t decode_target(input logic master, input logic s1_sel);
        r_state_t route;
        if (master == M0_IDX) begin
            route = R_M0_S0;
        end else if (s1_sel) begin
            route = R_M1_S1;
        end else begin
            route = R_M1_S0;
        end
        return route;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
//   Two-requester round-robin arbiter. The grant is combinational; the
//   memory of the last winner is registered and advances only when the
//   caller pulses update while some request is present.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     req[1:0]   request per master (bit index = master index)
//     update     take the current grant (advance last winner)
//     grant[1:0] one-hot grant, all-zero when nobody requests
// ---------------------------------------------------------------------------
module rr_arbiter2
    import axi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_grant_r;

    // Lone requester wins; under contention the master not served last wins.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant_r == M1_IDX) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Last-winner memory; reset favours M0 on the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= M1_IDX;
        end else if (update && (grant != 2'b00)) begin
            last_grant_r <= grant[1];
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/read_addr_arbiter.sv
// ---------------------------------------------------------------------------
// read_addr_arbiter
//   Read-address front end of the AXI bridge. Arbitrates AR requests from
//   M0/M1, decodes the slave (S0/S1), forwards the AR handshake to it and
//   holds the path until the last R beat on that slave completes. Only one
//   read is outstanding bridge-wide. R_state is a register, so the
//   downstream read-data mux never sees a combinational path from ARVALID.
//   Ports:
//     ACLK, ARESET            clock, asynchronous active-high reset
//     AR*_M0 / AR*_M1         master AR channels (ARREADY_Mx is an output)
//     AR*_S0 / AR*_S1         slave AR channels (ARREADY_Sx is an input)
//     RVALID/RREADY/RLAST_Sx  R handshake, observed for completion only
//     R_state                 routing select: IDLE, R_M0_S0, R_M1_S0, R_M1_S1
// ---------------------------------------------------------------------------
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module read_addr_arbiter
    import axi_pkg::*;
#(
    parameter int S1_BASE_BIT = S1_BASE_BIT_DEFAULT,
    parameter int MID_BITS    = `AXI_IDS_BITS - `AXI_ID_BITS
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [`AXI_ID_BITS-1:0]   ARID_M0,
    input  logic [`AXI_ADDR_BITS-1:0] ARADDR_M0,
    input  logic [`AXI_LEN_BITS-1:0]  ARLEN_M0,
    input  logic [`AXI_SIZE_BITS-1:0] ARSIZE_M0,
    input  logic [1:0]                ARBURST_M0,
    input  logic                      ARVALID_M0,
    output logic                      ARREADY_M0,
    input  logic [`AXI_ID_BITS-1:0]   ARID_M1,
    input  logic [`AXI_ADDR_BITS-1:0] ARADDR_M1,
    input  logic [`AXI_LEN_BITS-1:0]  ARLEN_M1,
    input  logic [`AXI_SIZE_BITS-1:0] ARSIZE_M1,
    input  logic [1:0]                ARBURST_M1,
    input  logic                      ARVALID_M1,
    output logic                      ARREADY_M1,
    output logic [`AXI_IDS_BITS-1:0]  ARID_S0,
    output logic [`AXI_ADDR_BITS-1:0] ARADDR_S0,
    output logic [`AXI_LEN_BITS-1:0]  ARLEN_S0,
    output logic [`AXI_SIZE_BITS-1:0] ARSIZE_S0,
    output logic [1:0]                ARBURST_S0,
    output logic                      ARVALID_S0,
    input  logic                      ARREADY_S0,
    output logic [`AXI_IDS_BITS-1:0]  ARID_S1,
    output logic [`AXI_ADDR_BITS-1:0] ARADDR_S1,
    output logic [`AXI_LEN_BITS-1:0]  ARLEN_S1,
    output logic [`AXI_SIZE_BITS-1:0] ARSIZE_S1,
    output logic [1:0]                ARBURST_S1,
    output logic                      ARVALID_S1,
    input  logic                      ARREADY_S1,
    input  logic                      RVALID_S0,
    input  logic                      RREADY_S0,
    input  logic                      RLAST_S0,
    input  logic                      RVALID_S1,
    input  logic                      RREADY_S1,
    input  logic                      RLAST_S1,
    output logic [2:0]                R_state
);

    r_state_t                  state_r;
    logic                      ar_pending_r;
    logic [1:0]                grant_s;
    logic                      active_s;
    logic                      sel_m1_s;
    logic                      sel_s1_s;
    logic                      sel_valid_s;
    logic                      sel_ready_s;
    logic                      ar_hs_s;
    logic                      r_last_hs_s;
    logic [`AXI_IDS_BITS-1:0]  sel_id_s;
    logic [`AXI_ADDR_BITS-1:0] sel_addr_s;
    logic [`AXI_LEN_BITS-1:0]  sel_len_s;
    logic [`AXI_SIZE_BITS-1:0] sel_size_s;
    logic [1:0]                sel_burst_s;

    // Arbitration is only taken while IDLE, which also enforces the bubble
    // cycle after completion.
    rr_arbiter2 u_rr_arbiter2 (
        .clk    (ACLK),
        .rst    (ARESET),
        .req    ({ARVALID_M1, ARVALID_M0}),
        .update (state_r == IDLE),
        .grant  (grant_s)
    );

    // Owner/target flags from the routing state; unknown encodings own nothing.
    always_comb begin
        active_s = 1'b0;
        sel_m1_s = 1'b0;
        sel_s1_s = 1'b0;
        case (state_r)
            R_M0_S0: active_s = 1'b1;
            R_M1_S0: begin
                active_s = 1'b1;
                sel_m1_s = 1'b1;
            end
            R_M1_S1: begin
                active_s = 1'b1;
                sel_m1_s = 1'b1;
                sel_s1_s = 1'b1;
            end
            default: active_s = 1'b0;
        endcase
    end

    // Owner's AR payload (ID tagged with its master index) and the handshakes
    // of the selected pair.
    always_comb begin
        sel_valid_s = sel_m1_s ? ARVALID_M1 : ARVALID_M0;
        sel_ready_s = sel_s1_s ? ARREADY_S1 : ARREADY_S0;
        ar_hs_s     = sel_valid_s & sel_ready_s;
        r_last_hs_s = sel_s1_s ? (RVALID_S1 & RREADY_S1 & RLAST_S1)
                               : (RVALID_S0 & RREADY_S0 & RLAST_S0);
        if (sel_m1_s) begin
            sel_id_s    = {MID_BITS'(M1_IDX), ARID_M1};
            sel_addr_s  = ARADDR_M1;
            sel_len_s   = ARLEN_M1;
            sel_size_s  = ARSIZE_M1;
            sel_burst_s = ARBURST_M1;
        end else begin
            sel_id_s    = {MID_BITS'(M0_IDX), ARID_M0};
            sel_addr_s  = ARADDR_M0;
            sel_len_s   = ARLEN_M0;
            sel_size_s  = ARSIZE_M0;
            sel_burst_s = ARBURST_M0;
        end
    end

    // AR forwarding: only while the address is still pending, and only to the
    // selected slave / from the owning master; everything else reads zero.
    always_comb begin
        ARREADY_M0 = 1'b0;
        ARREADY_M1 = 1'b0;
        ARID_S0    = '0;
        ARADDR_S0  = '0;
        ARLEN_S0   = '0;
        ARSIZE_S0  = '0;
        ARBURST_S0 = 2'b00;
        ARVALID_S0 = 1'b0;
        ARID_S1    = '0;
        ARADDR_S1  = '0;
        ARLEN_S1   = '0;
        ARSIZE_S1  = '0;
        ARBURST_S1 = 2'b00;
        ARVALID_S1 = 1'b0;
        if (active_s && ar_pending_r) begin
            if (sel_s1_s) begin
                ARID_S1    = sel_id_s;
                ARADDR_S1  = sel_addr_s;
                ARLEN_S1   = sel_len_s;
                ARSIZE_S1  = sel_size_s;
                ARBURST_S1 = sel_burst_s;
                ARVALID_S1 = sel_valid_s;
            end else begin
                ARID_S0    = sel_id_s;
                ARADDR_S0  = sel_addr_s;
                ARLEN_S0   = sel_len_s;
                ARSIZE_S0  = sel_size_s;
                ARBURST_S0 = sel_burst_s;
                ARVALID_S0 = sel_valid_s;
            end
            if (sel_m1_s) begin
                ARREADY_M1 = sel_ready_s;
            end else begin
                ARREADY_M0 = sel_ready_s;
            end
        end else begin
            ARREADY_M0 = 1'b0;
            ARREADY_M1 = 1'b0;
        end
    end

    // Path ownership: grant from IDLE, drop pending on the AR handshake, then
    // release on the selected slave's last R beat. R beats during the address
    // phase are deliberately not looked at.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_r      <= IDLE;
            ar_pending_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s != 2'b00) begin
                        state_r      <= decode_target(grant_s[M1_IDX], ARADDR_M1[S1_BASE_BIT]);
                        ar_pending_r <= 1'b1;
                    end else begin
                        ar_pending_r <= 1'b0;
                    end
                end
                R_M0_S0, R_M1_S0, R_M1_S1: begin
                    if (ar_pending_r) begin
                        if (ar_hs_s) begin
                            ar_pending_r <= 1'b0;
                        end else begin
                            ar_pending_r <= 1'b1;
                        end
                    end else if (r_last_hs_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    ar_pending_r <= 1'b0;
                end
            endcase
        end
    end

    assign R_state = state_r;

endmodule

// File: tb/tb_read_addr_arbiter.sv
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module tb_read_addr_arbiter;

    logic                      ACLK;
    logic                      ARESET;
    logic [`AXI_ID_BITS-1:0]   ARID_M0, ARID_M1;
    logic [`AXI_ADDR_BITS-1:0] ARADDR_M0, ARADDR_M1;
    logic [`AXI_LEN_BITS-1:0]  ARLEN_M0, ARLEN_M1;
    logic [`AXI_SIZE_BITS-1:0] ARSIZE_M0, ARSIZE_M1;
    logic [1:0]                ARBURST_M0, ARBURST_M1;
    logic                      ARVALID_M0, ARVALID_M1;
    logic                      ARREADY_M0, ARREADY_M1;
    logic [`AXI_IDS_BITS-1:0]  ARID_S0, ARID_S1;
    logic [`AXI_ADDR_BITS-1:0] ARADDR_S0, ARADDR_S1;
    logic [`AXI_LEN_BITS-1:0]  ARLEN_S0, ARLEN_S1;
    logic [`AXI_SIZE_BITS-1:0] ARSIZE_S0, ARSIZE_S1;
    logic [1:0]                ARBURST_S0, ARBURST_S1;
    logic                      ARVALID_S0, ARVALID_S1;
    logic                      ARREADY_S0, ARREADY_S1;
    logic                      RVALID_S0, RREADY_S0, RLAST_S0;
    logic                      RVALID_S1, RREADY_S1, RLAST_S1;
    logic [2:0]                R_state;

    int total = 0;
    int bad   = 0;

    read_addr_arbiter dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
        .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
        .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
        .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
        .ARID_S0(ARID_S0), .ARADDR_S0(ARADDR_S0), .ARLEN_S0(ARLEN_S0), .ARSIZE_S0(ARSIZE_S0),
        .ARBURST_S0(ARBURST_S0), .ARVALID_S0(ARVALID_S0), .ARREADY_S0(ARREADY_S0),
        .ARID_S1(ARID_S1), .ARADDR_S1(ARADDR_S1), .ARLEN_S1(ARLEN_S1), .ARSIZE_S1(ARSIZE_S1),
        .ARBURST_S1(ARBURST_S1), .ARVALID_S1(ARVALID_S1), .ARREADY_S1(ARREADY_S1),
        .RVALID_S0(RVALID_S0), .RREADY_S0(RREADY_S0), .RLAST_S0(RLAST_S0),
        .RVALID_S1(RVALID_S1), .RREADY_S1(RREADY_S1), .RLAST_S1(RLAST_S1),
        .R_state(R_state)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Vector record: inputs {vm0,vm1,a16,rdy_s0,rdy_s1,rv_s0,rl_s0,rv_s1,rl_s1,rready},
    // expected R_state, {ARVALID_S0,ARVALID_S1,ARREADY_M0,ARREADY_M1}, ARID_S0, ARID_S1.
    typedef struct packed {
        logic [9:0] in;
        logic [2:0] st;
        logic [3:0] ar;
        logic [7:0] id0;
        logic [7:0] id1;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];
    logic a16, rr;

    task automatic drive_quiet();
        ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0;
        ARREADY_S0 = 1'b0; ARREADY_S1 = 1'b0;
        RVALID_S0 = 1'b0; RREADY_S0 = 1'b0; RLAST_S0 = 1'b0;
        RVALID_S1 = 1'b0; RREADY_S1 = 1'b0; RLAST_S1 = 1'b0;
    endtask

    task automatic fixed_payload();
        ARID_M0 = 4'h5; ARADDR_M0 = 32'h0000_1000; ARLEN_M0 = 4'd3; ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'b01;
        ARID_M1 = 4'hA; ARADDR_M1 = 32'h0000_0040; ARLEN_M1 = 4'd3; ARSIZE_M1 = 3'd2; ARBURST_M1 = 2'b01;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        drive_quiet();
        @(posedge ACLK);
        @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
    endtask

    // ---------------- reference model (transaction level) ----------------
    int   owner;   // -1 none, else master index owning the path
    int   tgt;     // slave index of the current transaction
    bit   aphase;  // address still to be accepted
    int   last;    // master granted most recently

    logic       m_v [2];
    logic [31:0] m_a [2];
    logic [3:0] m_id [2];
    logic [8:0] m_misc [2];
    logic       s_rdy [2], s_rv [2], s_rr [2], s_rl [2];

    task automatic model_check(input int cyc);
        int   exp_st;
        logic exp_vs [2];
        logic exp_rm [2];
        logic [7:0]  exp_id [2];
        logic [31:0] exp_ad [2];
        logic [8:0]  exp_mi [2];
        m_v = '{ARVALID_M0, ARVALID_M1};
        m_a = '{ARADDR_M0, ARADDR_M1};
        m_id = '{ARID_M0, ARID_M1};
        m_misc = '{{ARLEN_M0, ARSIZE_M0, ARBURST_M0}, {ARLEN_M1, ARSIZE_M1, ARBURST_M1}};
        s_rdy = '{ARREADY_S0, ARREADY_S1};
        s_rv = '{RVALID_S0, RVALID_S1};
        s_rr = '{RREADY_S0, RREADY_S1};
        s_rl = '{RLAST_S0, RLAST_S1};
        exp_st = (owner < 0) ? 0 : 1 + owner + tgt;
        for (int k = 0; k < 2; k++) begin
            exp_vs[k] = 1'b0; exp_rm[k] = 1'b0; exp_id[k] = 8'h00; exp_ad[k] = 32'h0; exp_mi[k] = 9'h0;
        end
        if (owner >= 0 && aphase) begin
            exp_vs[tgt] = m_v[owner];
            exp_rm[owner] = s_rdy[tgt];
            exp_id[tgt] = 8'(owner * 16 + int'(m_id[owner]));
            exp_ad[tgt] = m_a[owner];
            exp_mi[tgt] = m_misc[owner];
        end
        chk($sformatf("rnd%0d R_state", cyc), 64'(R_state), 64'(exp_st));
        chk($sformatf("rnd%0d handshake", cyc), 64'({ARVALID_S0, ARVALID_S1, ARREADY_M0, ARREADY_M1}),
            64'({exp_vs[0], exp_vs[1], exp_rm[0], exp_rm[1]}));
        chk($sformatf("rnd%0d ARID_S0", cyc), 64'(ARID_S0), 64'(exp_id[0]));
        chk($sformatf("rnd%0d ARID_S1", cyc), 64'(ARID_S1), 64'(exp_id[1]));
        chk($sformatf("rnd%0d ARADDR_S0", cyc), 64'(ARADDR_S0), 64'(exp_ad[0]));
        chk($sformatf("rnd%0d ARADDR_S1", cyc), 64'(ARADDR_S1), 64'(exp_ad[1]));
        chk($sformatf("rnd%0d misc_S0", cyc), 64'({ARLEN_S0, ARSIZE_S0, ARBURST_S0}), 64'(exp_mi[0]));
        chk($sformatf("rnd%0d misc_S1", cyc), 64'({ARLEN_S1, ARSIZE_S1, ARBURST_S1}), 64'(exp_mi[1]));
    endtask

    // What the next clock edge does to the transaction.
    task automatic model_step();
        int win;
        if (owner < 0) begin
            if (m_v[0] && m_v[1]) win = 1 - last;
            else if (m_v[0]) win = 0;
            else if (m_v[1]) win = 1;
            else win = -1;
            if (win >= 0) begin
                owner = win;
                last = win;
                tgt = (win == 1) ? int'(m_a[1][16]) : 0;
                aphase = 1'b1;
            end
        end else if (aphase) begin
            if (m_v[owner] && s_rdy[tgt]) aphase = 1'b0;
        end else if (s_rv[tgt] && s_rr[tgt] && s_rl[tgt]) begin
            owner = -1;
        end
    endtask

    int exp_seq [12] = '{0, 1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2};

    initial begin
        // -------- vector table --------
        vecs[0]  = '{10'b0000000001, 3'd0, 4'b0000, 8'h00, 8'h00};
        vecs[1]  = '{10'b1000000001, 3'd0, 4'b0000, 8'h00, 8'h00};
        vecs[2]  = '{10'b1000000001, 3'd1, 4'b1000, 8'h05, 8'h00};
        vecs[3]  = '{10'b1001000001, 3'd1, 4'b1010, 8'h05, 8'h00};
        vecs[4]  = '{10'b0000010001, 3'd1, 4'b0000, 8'h00, 8'h00};
        vecs[5]  = '{10'b0000010001, 3'd1, 4'b0000, 8'h00, 8'h00};
        vecs[6]  = '{10'b0000010001, 3'd1, 4'b0000, 8'h00, 8'h00};
        vecs[7]  = '{10'b0000011001, 3'd1, 4'b0000, 8'h00, 8'h00};
        vecs[8]  = '{10'b0000000001, 3'd0, 4'b0000, 8'h00, 8'h00};
        vecs[9]  = '{10'b0110000001, 3'd0, 4'b0000, 8'h00, 8'h00};
        vecs[10] = '{10'b0110100001, 3'd3, 4'b0101, 8'h00, 8'h1A};
        vecs[11] = '{10'b0000000111, 3'd3, 4'b0000, 8'h00, 8'h00};
        vecs[12] = '{10'b0000000001, 3'd0, 4'b0000, 8'h00, 8'h00};
        vecs[13] = '{10'b0100000001, 3'd0, 4'b0000, 8'h00, 8'h00};
        vecs[14] = '{10'b0101000001, 3'd2, 4'b1001, 8'h1A, 8'h00};
        vecs[15] = '{10'b0000011001, 3'd2, 4'b0000, 8'h00, 8'h00};
        vecs[16] = '{10'b0000000001, 3'd0, 4'b0000, 8'h00, 8'h00};
        vecs[17] = '{10'b1000000001, 3'd0, 4'b0000, 8'h00, 8'h00};
        vecs[18] = '{10'b1000011001, 3'd1, 4'b1000, 8'h05, 8'h00};
        vecs[19] = '{10'b1000011001, 3'd1, 4'b1000, 8'h05, 8'h00};
        vecs[20] = '{10'b1001000001, 3'd1, 4'b1010, 8'h05, 8'h00};
        vecs[21] = '{10'b0000000111, 3'd1, 4'b0000, 8'h00, 8'h00};
        vecs[22] = '{10'b0000011000, 3'd1, 4'b0000, 8'h00, 8'h00};
        vecs[23] = '{10'b0000011001, 3'd1, 4'b0000, 8'h00, 8'h00};
        vecs[24] = '{10'b0000000001, 3'd0, 4'b0000, 8'h00, 8'h00};

        fixed_payload();
        do_reset();
        chk("reset R_state", 64'(R_state), 64'd0);
        chk("reset handshake", 64'({ARVALID_S0, ARVALID_S1, ARREADY_M0, ARREADY_M1}), 64'd0);

        for (int i = 0; i < NV; i++) begin
            @(posedge ACLK); #1;
            {ARVALID_M0, ARVALID_M1, a16, ARREADY_S0, ARREADY_S1,
             RVALID_S0, RLAST_S0, RVALID_S1, RLAST_S1, rr} = vecs[i].in;
            ARADDR_M1 = {15'd0, a16, 16'h0040};
            RREADY_S0 = rr;
            RREADY_S1 = rr;
            @(negedge ACLK);
            chk($sformatf("vec%0d R_state", i), 64'(R_state), 64'(vecs[i].st));
            chk($sformatf("vec%0d handshake", i), 64'({ARVALID_S0, ARVALID_S1, ARREADY_M0, ARREADY_M1}), 64'(vecs[i].ar));
            chk($sformatf("vec%0d ARID_S0", i), 64'(ARID_S0), 64'(vecs[i].id0));
            chk($sformatf("vec%0d ARID_S1", i), 64'(ARID_S1), 64'(vecs[i].id1));
        end

        // -------- continuous contention from reset: M0, M1, M0, M1 with IDLE gaps --------
        fixed_payload();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(posedge ACLK); #1;
            ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b1; ARREADY_S0 = 1'b1;
            RVALID_S0 = 1'b1; RREADY_S0 = 1'b1; RLAST_S0 = 1'b1;
            @(negedge ACLK);
            chk($sformatf("rr%0d R_state", i), 64'(R_state), 64'(exp_seq[i]));
        end

        // -------- slave stalls AR for 5 cycles, then non-last beats --------
        @(posedge ACLK); #1;
        drive_quiet();
        ARVALID_M0 = 1'b1;
        @(negedge ACLK);
        chk("stall grant R_state", 64'(R_state), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge ACLK); #1;
            @(negedge ACLK);
            chk($sformatf("stall%0d R_state", i), 64'(R_state), 64'd1);
            chk($sformatf("stall%0d valid/ready", i), 64'({ARVALID_S0, ARREADY_M0}), 64'b10);
            chk($sformatf("stall%0d payload", i), 64'({ARID_S0, ARADDR_S0, ARLEN_S0}), 64'({8'h05, 32'h0000_1000, 4'd3}));
        end
        @(posedge ACLK); #1;
        ARREADY_S0 = 1'b1;
        @(negedge ACLK);
        chk("stall accept ARREADY_M0", 64'(ARREADY_M0), 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge ACLK); #1;
            drive_quiet();
            RVALID_S0 = 1'b1; RREADY_S0 = 1'b1; RLAST_S0 = 1'b0;
            @(negedge ACLK);
            chk($sformatf("beat%0d R_state", i), 64'(R_state), 64'd1);
        end
        @(posedge ACLK); #1;
        RLAST_S0 = 1'b1;
        @(posedge ACLK); #1;
        drive_quiet();
        @(negedge ACLK);
        chk("after last R_state", 64'(R_state), 64'd0);

        // -------- async reset mid-burst in R_M1_S1 --------
        @(posedge ACLK); #1;
        ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h0001_0040; ARREADY_S1 = 1'b1;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        chk("m1s1 ARVALID_S1", 64'({ARVALID_S1, ARVALID_S0, ARID_S1}), 64'({1'b1, 1'b0, 8'h1A}));
        @(posedge ACLK); #1;
        drive_quiet();
        ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b1;
        RVALID_S1 = 1'b1; RREADY_S1 = 1'b1;
        @(negedge ACLK);
        chk("midburst R_state", 64'(R_state), 64'd3);
        #2;
        ARESET = 1'b1;
        #1;
        chk("async reset R_state", 64'(R_state), 64'd0);
        chk("async reset handshake", 64'({ARVALID_S0, ARVALID_S1, ARREADY_M0, ARREADY_M1}), 64'd0);
        @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        RVALID_S1 = 1'b0;
        @(posedge ACLK); #1;
        @(negedge ACLK);
        chk("post reset grant", 64'(R_state), 64'd1);

        // -------- randomized run against the model --------
        do_reset();
        owner = -1; tgt = 0; aphase = 1'b0; last = 1;
        for (int c = 0; c < 1500; c++) begin
            @(posedge ACLK); #1;
            ARVALID_M0 = 1'($urandom_range(0, 1));
            ARVALID_M1 = 1'($urandom_range(0, 1));
            ARID_M0 = 4'($urandom); ARID_M1 = 4'($urandom);
            ARADDR_M0 = $urandom; ARADDR_M1 = $urandom;
            ARLEN_M0 = 4'($urandom); ARLEN_M1 = 4'($urandom);
            ARSIZE_M0 = 3'($urandom); ARSIZE_M1 = 3'($urandom);
            ARBURST_M0 = 2'($urandom); ARBURST_M1 = 2'($urandom);
            ARREADY_S0 = 1'($urandom_range(0, 1));
            ARREADY_S1 = 1'($urandom_range(0, 1));
            RVALID_S0 = 1'($urandom_range(0, 1));
            RVALID_S1 = 1'($urandom_range(0, 1));
            RREADY_S0 = ($urandom_range(0, 9) < 7);
            RREADY_S1 = ($urandom_range(0, 9) < 7);
            RLAST_S0 = ($urandom_range(0, 9) < 3);
            RLAST_S1 = ($urandom_range(0, 9) < 3);
            @(negedge ACLK);
            model_check(c);
            model_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
